// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-rate raster timing generator (counters, sync, video_on, line/frame markers)
// Optional per-frame counter output enabled by VGA_SYNC_FRAME_COUNT_EN.
module vga_sync_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int CLK_DIV         = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
      $error("vga_sync_gen: H_TOTAL/V_TOTAL must fit 10 bits and CLK_DIV must be >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             pixel_tick_q, pixel_tick_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             div_wrap;

  // Every registered output is decoded from the next-state counters so it
  // lines up with pixelx/pixely in the same cycle.
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    x_d      = x_q;
    y_d      = y_q;
    if (div_wrap) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    pixel_tick_d  = div_wrap;
    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d       = (x_d >= HS_START && x_d < HS_END) ? SYNC_ON : SYNC_OFF;
    vsync_d       = (y_d >= VS_START && y_d < VS_END) ? SYNC_ON : SYNC_OFF;
    line_start_d  = div_wrap && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      pixel_tick_q  <= 1'b0;
      video_on_q    <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_tick_q  <= pixel_tick_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign pixel_tick  = pixel_tick_q;
  assign pixelx      = x_q;
  assign pixely      = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
